// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared state enum, default widths and bus slice helper for the sprite ROM arbiter
package sprite_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF = 14;
  localparam int DW_DEF = 12;
  localparam int LENW_DEF = 4;
  function automatic logic [31:0] slice(input logic [255:0] bus, input int k, input int w);
    return 32'(bus >> (k * w)) & ~(32'hFFFF_FFFF << w);
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester, ROM and read-return signals of the sprite ROM arbiter
interface sprite_rom_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LENW = LENW_DEF
);
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [NREQ-1:0] rd_valid;
  logic rd_last;
  logic [DW-1:0] rd_data;
  modport master (
    output req, req_addr, req_len, rom_data,
    input gnt, busy, rom_en, rom_addr, rd_valid, rd_last, rd_data
  );
  modport slave (
    input req, req_addr, req_len, rom_data,
    output gnt, busy, rom_en, rom_addr, rd_valid, rd_last, rd_data
  );
endinterface

// File: rtl/sprite_rr_pick.sv
// sprite_rr_pick: rotate-priority picker starting at ptr, optional fixed priority for requester 0
module sprite_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input logic [NREQ-1:0] req,
  input logic [IW-1:0] ptr,
  input logic fix,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0] idx,
  output logic any
);
  always_comb begin
    int j;
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
    idx = fix && req[0] ? '0 : idx;
    win = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin burst arbiter for a shared sprite ROM (SPRITE_ARB_FIXPRIO_EN gives requester 0 fixed priority)
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LENW = LENW_DEF
) (
  input logic clk,
  input logic rst_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
`ifdef SPRITE_ARB_FIXPRIO_EN
  localparam logic FIX = 1'b1;
`else
  localparam logic FIX = 1'b0;
`endif
  localparam logic [IW-1:0] PTR_RST = FIX ? IW'(1) : '0;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner, owner_n, w, ptr_inc;
  logic [AW-1:0] addr, addr_n;
  logic [LENW-1:0] beats, beats_n;
  logic [NREQ-1:0] gnt_n, win, cand, own_oh;
  logic any, last, run, load;
  // the owner stays out of arbitration until its last beat has been issued
  assign own_oh = NREQ'(1) << owner;
  assign cand = bus.req & ~(state == BURST ? own_oh : '0);
  sprite_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(cand),
    .ptr(ptr),
    .fix(FIX),
    .win(win),
    .idx(w),
    .any(any)
  );
  assign last = state == BURST && beats == '0;
  assign run = state == BURST && !last;
  assign load = any && (state == IDLE || last);
  assign ptr_inc = w == IW'(NREQ - 1) ? '0 : w + 1'b1;
  assign bus.rom_addr = addr;
  assign bus.rd_data = DW'(bus.rom_data);
  always_comb begin
    state_n = load ? BURST : last ? IDLE : state;
    owner_n = load ? w : owner;
    ptr_n = load ? (FIX && ptr_inc == '0 ? IW'(1) : ptr_inc) : ptr;
    gnt_n = load ? win : '0;
    addr_n = load ? AW'(slice(256'(bus.req_addr), int'(w), AW)) : run ? addr + 1'b1 : addr;
    beats_n = load ? LENW'(slice(256'(bus.req_len), int'(w), LENW)) : run ? beats - 1'b1 : beats;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= PTR_RST;
      owner <= '0;
      addr <= '0;
      beats <= '0;
      bus.gnt <= '0;
      bus.busy <= 1'b0;
      bus.rom_en <= 1'b0;
      bus.rd_valid <= '0;
      bus.rd_last <= 1'b0;
    end else begin
      ptr <= ptr_n;
      owner <= owner_n;
      addr <= addr_n;
      beats <= beats_n;
      bus.gnt <= gnt_n;
      bus.busy <= state_n == BURST;
      bus.rom_en <= state_n == BURST;
      bus.rd_valid <= state == BURST ? own_oh : '0;
      bus.rd_last <= last;
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: randomized bench against a beat-queue reference model of the sprite ROM arbiter
module tb_sprite_rom_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 14;
  localparam int DW = 12;
  localparam int LENW = 4;
`ifdef SPRITE_ARB_FIXPRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif
  typedef struct {
    int addr;
    int owner;
    bit last;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] rq;
  logic [AW-1:0] ra[NREQ];
  logic [LENW-1:0] rl[NREQ];
  logic [DW-1:0] romv;
  beat_t q[$];
  beat_t cur, prev;
  bit cur_v, prev_v, counting;
  int ptr, n_cmp, n_err;
  int cnt[NREQ];
  logic [NREQ-1:0] egnt;
  int wrap_exp[4] = '{32'h3FFE, 32'h3FFF, 32'h0000, 32'h0001};
  always #5 clk = ~clk;
  sprite_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW)) bus ();
  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  assign bus.req = rq;
  assign bus.rom_data = romv;
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign bus.req_addr[g*AW +: AW] = ra[g];
    assign bus.req_len[g*LENW +: LENW] = rl[g];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    cur_v = 1'b0;
    prev_v = 1'b0;
    egnt = '0;
    ptr = FIX ? 1 : 0;
  endtask
  function automatic int pick(input int excl);
    int k;
    if (FIX && rq[0] && excl != 0) return 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (ptr + i) % NREQ;
      if (rq[k] && k != excl) return k;
    end
    return -1;
  endfunction
  // a grant expands into its full list of beats; the next arbitration happens once that list runs dry
  task automatic model_edge();
    int w, len;
    prev = cur;
    prev_v = cur_v;
    egnt = '0;
    if (q.size() > 0) cur = q.pop_front();
    else begin
      w = pick(cur_v ? cur.owner : -1);
      cur_v = w >= 0;
      if (cur_v) begin
        len = int'(rl[w]) + 1;
        for (int i = 0; i < len; i++)
          q.push_back('{addr: (int'(ra[w]) + i) % (1 << AW), owner: w, last: i == len - 1});
        cur = q.pop_front();
        egnt[w] = 1'b1;
        ptr = (w + 1) % NREQ;
        if (FIX && ptr == 0) ptr = 1;
      end
    end
  endtask
  task automatic check_outputs();
    chk("gnt", 32'(bus.gnt), 32'(egnt));
    chk("busy", 32'(bus.busy), 32'(cur_v));
    chk("rom_en", 32'(bus.rom_en), 32'(cur_v));
    if (cur_v) chk("rom_addr", 32'(bus.rom_addr), 32'(cur.addr));
    chk("rd_valid", 32'(bus.rd_valid), prev_v ? 32'(1) << prev.owner : 32'(0));
    chk("rd_last", 32'(bus.rd_last), 32'(prev_v && prev.last));
    if (prev_v) chk("rd_data", 32'(bus.rd_data), 32'(romv));
    if (counting)
      for (int k = 0; k < NREQ; k++) if (bus.rd_valid[k]) cnt[k]++;
  endtask
  task automatic reset_checks();
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_rom_en", 32'(bus.rom_en), 32'(0));
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
    chk("rst_rd_last", 32'(bus.rd_last), 32'(0));
  endtask
  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
    romv = DW'($urandom);
  endtask
  task automatic set_req(input int k, input int a, input int l);
    ra[k] = AW'(a);
    rl[k] = LENW'(l);
    rq[k] = 1'b1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic agents(input int p_raise);
    for (int k = 0; k < NREQ; k++)
      if (egnt[k]) begin
        if ($urandom_range(1) == 1) rq[k] = 1'b0;
        else set_req(k, $urandom_range(3) == 0 ? 'h3FF0 + $urandom_range(15) : $urandom, $urandom);
      end else if (!rq[k] && $urandom_range(99) < p_raise)
        set_req(k, $urandom_range(3) == 0 ? 'h3FF0 + $urandom_range(15) : $urandom, $urandom);
  endtask
  initial begin
    rq = '0;
    for (int k = 0; k < NREQ; k++) begin
      ra[k] = '0;
      rl[k] = '0;
      cnt[k] = 0;
    end
    romv = '0;
    counting = 1'b0;
    n_cmp = 0;
    n_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;
    set_req(1, 'h0100, 3);
    step();
    chk("single_gnt", 32'(bus.gnt), 32'b0010);
    rq[1] = 1'b0;
    repeat (6) step();
    do_reset();
    set_req(0, 'h0200, 0);
    set_req(2, 'h0300, 0);
    step();
    chk("contend_first", 32'(bus.gnt), 32'b0001);
    rq[0] = 1'b0;
    step();
    chk("contend_second", 32'(bus.gnt), 32'b0100);
    rq[2] = 1'b0;
    repeat (3) step();
    set_req(1, 'h0400, 0);
    set_req(3, 'h0500, 0);
    step();
    chk("contend_ptr3", 32'(bus.gnt), 32'b1000);
    rq[3] = 1'b0;
    step();
    rq[1] = 1'b0;
    repeat (3) step();
    set_req(3, 'h3FFE, 3);
    step();
    rq[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", 32'(bus.rom_addr), 32'(wrap_exp[i]));
      step();
    end
    repeat (3) step();
    for (int k = 0; k < NREQ; k++) set_req(k, $urandom, 1);
    for (int c = 0; c < 30; c++) begin
      counting = c >= 6 && c < 22;
      step();
      for (int k = 0; k < NREQ; k++) if (egnt[k]) set_req(k, $urandom, 1);
    end
    counting = 1'b0;
    for (int k = 0; k < NREQ; k++) chk("fair_beats", 32'(cnt[k]), 32'(4));
    rq = '0;
    repeat (4) step();
    set_req(3, 'h0600, 2);
    set_req(0, 'h0700, 1);
    for (int c = 0; c < 12; c++) begin
      step();
      if (egnt[0]) set_req(0, $urandom, 1);
      if (egnt[3]) rq[3] = 1'b0;
    end
    rq = '0;
    repeat (6) step();
    set_req(2, 'h1234, 7);
    step();
    rq[2] = 1'b0;
    step();
    do_reset();
    repeat (5) step();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset();
        rq = '0;
      end
      step();
      agents(30);
    end
    rq = '0;
    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
